// File: rtl/spi_slave_tx_split_pkg.sv
// Shared types and constants for the SPI return-path byte splitter.
// Optional checksum byte is enabled by defining SPI_TX_CSUM_EN.
package spi_tx_pkg;

    localparam int         BYTE_W        = 8;
    localparam logic [7:0] FILL_BYTE_DEF = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        CSUM = 2'd3
    } tx_state_t;

    function automatic int nbytes(input int word_w);
        return word_w / BYTE_W;
    endfunction

endpackage

// File: rtl/spi_slave_tx_split_if.sv
// Word-in / byte-out bundle between the controller, the splitter and the SPI slave.
interface spi_slave_tx_split_if
    import spi_tx_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int DEPTH  = 4
);
    logic                       i_Word_DV;
    logic [WORD_W-1:0]          i_Word;
    logic                       o_Word_Ready;
    logic                       o_Overflow;
    logic [$clog2(DEPTH+1)-1:0] o_Fill;
    logic                       i_Byte_Done;
    logic                       i_CS_n;
    logic                       o_TX_DV;
    logic [BYTE_W-1:0]          o_TX_Byte;
    logic                       o_Irq;

    modport slave (
        input  i_Word_DV, i_Word, i_Byte_Done, i_CS_n,
        output o_Word_Ready, o_Overflow, o_Fill, o_TX_DV, o_TX_Byte, o_Irq
    );

    modport master (
        output i_Word_DV, i_Word, i_Byte_Done, i_CS_n,
        input  o_Word_Ready, o_Overflow, o_Fill, o_TX_DV, o_TX_Byte, o_Irq
    );
endinterface

// File: rtl/spi_slave_tx_split_fifo.sv
// First-word-fall-through word FIFO; a push at full is accepted only alongside a pop.
module spi_tx_fifo
    import spi_tx_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == CW'(0));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end
endmodule

// File: rtl/spi_slave_tx_split.sv
// Splits queued words into MSB-first bytes for the SPI slave TX port.
// Define SPI_TX_CSUM_EN to append an XOR checksum byte to every word.
module spi_slave_tx_split
    import spi_tx_pkg::*;
#(
    parameter int          WORD_W    = 64,
    parameter int          DEPTH     = 4,
    parameter logic [7:0]  FILL_BYTE = FILL_BYTE_DEF
) (
    input logic                 clk,
    input logic                 rst,
    spi_slave_tx_split_if.slave bus
);
    localparam int NB = nbytes(WORD_W);
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WORD_W-1:0] fifo_dout;
    logic              fifo_full, fifo_empty, pop_s, push_ok;
    logic [CW-1:0]     fifo_count, fill_nxt;

    logic              cs_meta_q, cs_sync_q, cs_prev_q, cs_rise;
    tx_state_t         state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              tx_dv_q, tx_dv_d;
    logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
    logic              irq_q, ready_q, ovf_q, ovf_d, word_end;
    logic [BYTE_W-1:0] word_bytes [NB];
    logic [BYTE_W-1:0] next_byte, head_msb;
`ifdef SPI_TX_CSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
`endif

    spi_tx_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.i_Word_DV),
        .pop   (pop_s),
        .din   (bus.i_Word),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    for (genvar k = 0; k < NB; k++) begin : g_bytes
        assign word_bytes[k] = shift_q[WORD_W-1-BYTE_W*k -: BYTE_W];
    end

    assign head_msb  = fifo_dout[WORD_W-1 -: BYTE_W];
    assign next_byte = (idx_q == IW'(NB-1)) ? word_bytes[0] : word_bytes[idx_q + IW'(1)];
    assign cs_rise   = cs_sync_q & ~cs_prev_q;
    assign push_ok   = bus.i_Word_DV & (~fifo_full | pop_s);
    assign fill_nxt  = fifo_count + CW'(push_ok) - CW'(pop_s);
    assign ovf_d     = ovf_q | (bus.i_Word_DV & ~push_ok);

    // FSM next-state, byte selection and strobe generation
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        pop_s     = 1'b0;
        word_end  = 1'b0;
`ifdef SPI_TX_CSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (fifo_empty) begin
                    tx_dv_d   = bus.i_Byte_Done;
                    tx_byte_d = bus.i_Byte_Done ? FILL_BYTE : tx_byte_q;
                end else if (cs_sync_q || bus.i_Byte_Done) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                pop_s     = 1'b1;
                shift_d   = fifo_dout;
                idx_d     = IW'(0);
                tx_dv_d   = 1'b1;
                tx_byte_d = head_msb;
                state_d   = SEND;
`ifdef SPI_TX_CSUM_EN
                csum_d    = head_msb;
`endif
            end
            SEND: begin
                // A CS rise outranks a coincident byte-done: the word restarts from its MSB
                if (cs_rise && (idx_q != IW'(0))) begin
                    idx_d     = IW'(0);
                    tx_dv_d   = 1'b1;
                    tx_byte_d = word_bytes[0];
`ifdef SPI_TX_CSUM_EN
                    csum_d    = word_bytes[0];
`endif
                end else if (bus.i_Byte_Done && (idx_q != IW'(NB-1))) begin
                    idx_d     = idx_q + IW'(1);
                    tx_dv_d   = 1'b1;
                    tx_byte_d = next_byte;
`ifdef SPI_TX_CSUM_EN
                    csum_d    = csum_q ^ next_byte;
`endif
                end else if (bus.i_Byte_Done) begin
`ifdef SPI_TX_CSUM_EN
                    state_d   = CSUM;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = csum_q;
`else
                    word_end  = 1'b1;
`endif
                end else begin
                    state_d = SEND;
                end
            end
`ifdef SPI_TX_CSUM_EN
            CSUM: begin
                if (cs_rise) begin
                    state_d   = SEND;
                    idx_d     = IW'(0);
                    tx_dv_d   = 1'b1;
                    tx_byte_d = word_bytes[0];
                    csum_d    = word_bytes[0];
                end else begin
                    word_end  = bus.i_Byte_Done;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (word_end && !fifo_empty) begin
            state_d = LOAD;
        end else if (word_end) begin
            state_d   = IDLE;
            tx_dv_d   = 1'b1;
            tx_byte_d = FILL_BYTE;
        end else begin
            state_d = state_d;
        end
    end

    // CS synchroniser, FSM state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_meta_q <= 1'b1;
            cs_sync_q <= 1'b1;
            cs_prev_q <= 1'b1;
            state_q   <= IDLE;
            idx_q     <= IW'(0);
            shift_q   <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            irq_q     <= 1'b0;
            ready_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            cs_meta_q <= bus.i_CS_n;
            cs_sync_q <= cs_meta_q;
            cs_prev_q <= cs_sync_q;
            state_q   <= state_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            irq_q     <= (state_q != IDLE) | (fifo_count != CW'(0));
            ready_q   <= (fill_nxt != CW'(DEPTH));
            ovf_q     <= ovf_d;
        end
    end

`ifdef SPI_TX_CSUM_EN
    // Running XOR of the bytes strobed so far in the current word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign bus.o_TX_DV      = tx_dv_q;
    assign bus.o_TX_Byte    = tx_byte_q;
    assign bus.o_Irq        = irq_q;
    assign bus.o_Word_Ready = ready_q;
    assign bus.o_Overflow   = ovf_q;
    assign bus.o_Fill       = fifo_count;
endmodule
